// File: rtl/ahb5_pkg.sv
// Shared AHB5-Lite encodings for the SRAM subordinate.
// Holds HTRANS/HSIZE/HRESP codes, the slave FSM state type and a helper
// that turns a transfer size plus address low bits into byte-lane enables.
package ahb5_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StData = 2'b01,
        StErr1 = 2'b10,
        StErr2 = 2'b11
    } slave_state_e;

    // Little-endian lane enables; only legal sizes reach the write path.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lsb;
            HSIZE_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb5_sram_array.sv
// Word-organised SRAM: MEM_WORDS x 32 bits.
// Ports:
//   clk    write clock
//   we     write enable
//   be     per-byte write enables (bit n covers data[8n+7:8n])
//   waddr  write word index
//   wdata  write data
//   raddr  read word index
//   rdata  asynchronous read data
module ahb5_sram_array #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb5_sram_slave.sv
// AHB5-Lite subordinate in front of a word-organised SRAM.
// Serves byte/halfword/word reads and writes with WAIT_STATES wait cycles per
// OKAY data phase, and the two-cycle ERROR response for out-of-range,
// misaligned, bad-size or non-secure-into-secure-region accesses.
// Ports:
//   hclk, hreset             clock, synchronous active-high reset
//   hsel, haddr, htrans      address-phase select, byte address, transfer type
//   hwrite, hsize, hburst    direction, size, burst (burst ignored)
//   hnonsec, hmastlock       security attribute, lock (lock ignored)
//   hwdata                   write data (data phase)
//   hreadyin                 bus-level ready; gates address-phase acceptance
//   hreadyout, hresp, hrdata slave ready, response, read data
module ahb5_sram_slave
    import ahb5_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned SEC_WORDS   = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hnonsec,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    slave_state_e  state;
    logic [CW-1:0] cnt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;

    logic          accept;
    logic          addr_err;
    logic          done;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic [31:0]   word_idx;
    slave_state_e  next_state;

    logic unused_ctrl;
    assign unused_ctrl = ^{hburst, hmastlock};

    always_comb begin
        accept   = hsel && hreadyin && htrans[1];
        word_idx = {2'b00, haddr[31:2]};
        addr_err = 1'b0;
        // MEM_WORDS is a power of two, so any set bit above the index is out of range
        if (haddr[31:AW+2] != '0) addr_err = 1'b1;
        if (hsize > HSIZE_WORD) addr_err = 1'b1;
        if (hsize == HSIZE_HALF && haddr[0]) addr_err = 1'b1;
        if (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) addr_err = 1'b1;
        if (hnonsec && word_idx < SEC_WORDS) addr_err = 1'b1;

        if (!accept)      next_state = StIdle;
        else if (addr_err) next_state = StErr1;
        else               next_state = StData;

        // Edges at which a new address phase may be taken
        done = (state == StIdle) || (state == StErr2) || (state == StData && cnt == '0);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= StIdle;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
        end else if (state == StErr1) begin
            state <= StErr2;
        end else if (!done) begin
            cnt <= cnt - 1'b1;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q  <= haddr[AW+1:0];
                write_q <= hwrite;
                size_q  <= hsize;
                cnt     <= CW'(WAIT_STATES);
            end
        end
    end

    // Write lands on the edge that ends the data phase; reset on that edge cancels it
    assign mem_we = (state == StData) && (cnt == '0) && write_q && !hreset;
    assign mem_be = byte_lanes(size_q, addr_q[1:0]);

    ahb5_sram_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_array (
        .clk   (hclk),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (addr_q[AW+1:2]),
        .wdata (hwdata),
        .raddr (addr_q[AW+1:2]),
        .rdata (mem_rdata)
    );

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        unique case (state)
            StData: begin
                hreadyout = (cnt == '0);
                if (cnt == '0) hrdata = mem_rdata;
            end
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            StErr2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

endmodule
